// File: rtl/fft_cmul_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fft_cmul_pipe
// Description : Four-stage complex fractional multiplier y = a*w or a*conj(w)
//               with valid/ready flow control, rounding and saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_cmul_pipe #(
    parameter int DW    = 16,
    parameter int TW    = 8,
    parameter int TAG_W = 4,
    parameter int ROUND = 1,
    parameter int SAT   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_conj,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [DW-1:0]    a_re,
    input  logic [DW-1:0]    a_im,
    input  logic [TW-1:0]    w_re,
    input  logic [TW-1:0]    w_im,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    y_re,
    output logic [DW-1:0]    y_im,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_sat
);

    localparam int PW = DW + TW + 1;
    localparam int SW = DW + TW + 2;
    localparam logic signed [SW-1:0] RND_C   = (ROUND != 0) ? (SW'(1) << (TW - 2)) : '0;
    localparam logic        [DW-1:0] MAX_C   = {1'b0, {(DW-1){1'b1}}};
    localparam logic        [DW-1:0] MIN_C   = {1'b1, {(DW-1){1'b0}}};

    logic                    adv;
    logic signed [TW:0]      wi_s1_d;
    logic signed [SW-1:0]    re3_d, im3_d;
    logic        [DW:0]      yre_d, yim_d;

    logic                    v1_q, v2_q, v3_q, v4_q;
    logic signed [DW-1:0]    ar1_q, ai1_q;
    logic signed [TW-1:0]    wr1_q;
    logic signed [TW:0]      wi1_q;
    logic signed [PW-1:0]    rr2_q, ii2_q, ri2_q, ir2_q;
    logic signed [SW-1:0]    re3_q, im3_q;
    logic        [TAG_W-1:0] tag1_q, tag2_q, tag3_q, tag4_q;
    logic        [DW-1:0]    yre4_q, yim4_q;
    logic                    sat4_q;

    // Returns {overflow, result}; overflow means the scaled value left DW-bit range.
    function automatic logic [DW:0] scale_f(input logic signed [SW-1:0] v);
        logic signed [SW-1:0] t;
        logic                 ovf;
        logic [DW-1:0]        y;
        t   = (v + RND_C) >>> (TW - 1);
        ovf = (t[SW-1:DW-1] != {(SW-DW+1){t[SW-1]}});
        if (ovf && (SAT != 0)) begin
            y = t[SW-1] ? MIN_C : MAX_C;
        end else begin
            y = t[DW-1:0];
        end
        return {ovf, y};
    endfunction

    assign adv      = ~v4_q | out_ready;
    assign in_ready = adv;

    // Negation in TW+1 bits keeps -(-2^(TW-1)) exact.
    assign wi_s1_d = in_conj ? -{w_im[TW-1], w_im} : {w_im[TW-1], w_im};
    assign re3_d   = SW'(rr2_q) - SW'(ii2_q);
    assign im3_d   = SW'(ri2_q) + SW'(ir2_q);
    assign yre_d   = scale_f(re3_q);
    assign yim_d   = scale_f(im3_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            v4_q   <= 1'b0;
            ar1_q  <= '0;
            ai1_q  <= '0;
            wr1_q  <= '0;
            wi1_q  <= '0;
            rr2_q  <= '0;
            ii2_q  <= '0;
            ri2_q  <= '0;
            ir2_q  <= '0;
            re3_q  <= '0;
            im3_q  <= '0;
            tag1_q <= '0;
            tag2_q <= '0;
            tag3_q <= '0;
            tag4_q <= '0;
            yre4_q <= '0;
            yim4_q <= '0;
            sat4_q <= 1'b0;
        end else if (adv) begin
            v1_q <= in_valid;
            v2_q <= v1_q;
            v3_q <= v2_q;
            v4_q <= v3_q;
            if (in_valid) begin
                ar1_q  <= a_re;
                ai1_q  <= a_im;
                wr1_q  <= w_re;
                wi1_q  <= wi_s1_d;
                tag1_q <= in_tag;
            end
            if (v1_q) begin
                rr2_q  <= PW'(ar1_q) * PW'(wr1_q);
                ii2_q  <= PW'(ai1_q) * PW'(wi1_q);
                ri2_q  <= PW'(ar1_q) * PW'(wi1_q);
                ir2_q  <= PW'(ai1_q) * PW'(wr1_q);
                tag2_q <= tag1_q;
            end
            if (v2_q) begin
                re3_q  <= re3_d;
                im3_q  <= im3_d;
                tag3_q <= tag2_q;
            end
            if (v3_q) begin
                yre4_q <= yre_d[DW-1:0];
                yim4_q <= yim_d[DW-1:0];
                sat4_q <= yre_d[DW] | yim_d[DW];
                tag4_q <= tag3_q;
            end
        end
    end

    assign out_valid = v4_q;
    assign y_re      = yre4_q;
    assign y_im      = yim4_q;
    assign out_tag   = tag4_q;
    assign out_sat   = sat4_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_cmul_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_cmul_pipe
// Description : Self-checking bench; DUT pair (round/saturate and floor/wrap).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_cmul_pipe;

    localparam int DW    = 16;
    localparam int TW    = 8;
    localparam int TAG_W = 4;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [DW-1:0]    re;
        logic [DW-1:0]    im;
        logic             sat;
        logic [DW-1:0]    re2;
        logic [DW-1:0]    im2;
        logic             sat2;
    } res_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_conj = 1'b0;
    logic             out_ready = 1'b1;
    logic [TAG_W-1:0] in_tag = '0;
    logic [DW-1:0]    a_re = '0, a_im = '0;
    logic [TW-1:0]    w_re = '0, w_im = '0;
    logic             in_ready, out_valid, out_sat, in_ready2, out_valid2, out_sat2;
    logic [DW-1:0]    y_re, y_im, y_re2, y_im2;
    logic [TAG_W-1:0] out_tag, out_tag2;

    int   checks = 0;
    int   failures = 0;
    bit   done;
    res_t exp_q[$];
    res_t obs_q[$];

    // Directed vectors: inputs, then expected {re, im, sat} for round/sat and floor/wrap.
    localparam logic [15:0] T_AR [7] = '{16'h4000, 16'h4000, 16'h4000, 16'h0001, 16'hFFFF, 16'h8000, 16'h0000};
    localparam logic [15:0] T_AI [7] = '{16'h0000, 16'h4000, 16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h8000};
    localparam logic [7:0]  T_WR [7] = '{8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h80, 8'h40};
    localparam logic [7:0]  T_WI [7] = '{8'h00, 8'h40, 8'h40, 8'h00, 8'h00, 8'h00, 8'h80};
    localparam logic        T_CJ [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam logic [15:0] T_YR [7] = '{16'h2000, 16'h0000, 16'h4000, 16'h0001, 16'h0000, 16'h7FFF, 16'h7FFF};
    localparam logic [15:0] T_YI [7] = '{16'h0000, 16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hC000};
    localparam logic        T_S  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    localparam logic [15:0] T_YR2[7] = '{16'h2000, 16'h0000, 16'h4000, 16'h0000, 16'hFFFF, 16'h8000, 16'h8000};
    localparam logic [15:0] T_YI2[7] = '{16'h0000, 16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hC000};

    fft_cmul_pipe #(.DW(DW), .TW(TW), .TAG_W(TAG_W), .ROUND(1), .SAT(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_conj(in_conj),
        .in_tag(in_tag), .a_re(a_re), .a_im(a_im), .w_re(w_re), .w_im(w_im),
        .out_valid(out_valid), .out_ready(out_ready), .y_re(y_re), .y_im(y_im),
        .out_tag(out_tag), .out_sat(out_sat)
    );

    fft_cmul_pipe #(.DW(DW), .TW(TW), .TAG_W(TAG_W), .ROUND(0), .SAT(0)) u_dut_fw (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .in_conj(in_conj),
        .in_tag(in_tag), .a_re(a_re), .a_im(a_im), .w_re(w_re), .w_im(w_im),
        .out_valid(out_valid2), .out_ready(out_ready), .y_re(y_re2), .y_im(y_im2),
        .out_tag(out_tag2), .out_sat(out_sat2)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready)
            obs_q.push_back({out_tag, y_re, y_im, out_sat, y_re2, y_im2, out_sat2});
    end

    // Reference: exact integer product, then floor((v + r) / 2^(TW-1)) and range handling.
    function automatic void scale(input longint v, input bit rnd, input bit sat,
                                  output logic [DW-1:0] y, output logic o);
        longint s;
        longint maxv;
        longint minv;
        maxv = (64'sd1 <<< (DW - 1)) - 1;
        minv = -(64'sd1 <<< (DW - 1));
        s = (v + (rnd ? (64'sd1 <<< (TW - 2)) : 64'sd0)) >>> (TW - 1);
        o = (s > maxv) || (s < minv);
        if (o && sat) y = (s > 0) ? maxv[DW-1:0] : minv[DW-1:0];
        else          y = s[DW-1:0];
    endfunction

    function automatic res_t model(input logic [DW-1:0] ar, input logic [DW-1:0] ai,
                                   input logic [TW-1:0] wr, input logic [TW-1:0] wi,
                                   input logic cj, input logic [TAG_W-1:0] tg);
        longint xr, xi, vr, vi, re, im;
        logic [DW-1:0] r1, i1, r2, i2;
        logic o1, o2, o3, o4;
        res_t r;
        xr = longint'($signed(ar));
        xi = longint'($signed(ai));
        vr = longint'($signed(wr));
        vi = cj ? -longint'($signed(wi)) : longint'($signed(wi));
        re = xr * vr - xi * vi;
        im = xr * vi + xi * vr;
        scale(re, 1'b1, 1'b1, r1, o1);
        scale(im, 1'b1, 1'b1, i1, o2);
        scale(re, 1'b0, 1'b0, r2, o3);
        scale(im, 1'b0, 1'b0, i2, o4);
        r = {tg, r1, i1, o1 | o2, r2, i2, o3 | o4};
        return r;
    endfunction

    function automatic logic [DW-1:0] rnd_d();
        logic [DW-1:0] v;
        case ($urandom % 5)
            0:       v = {1'b1, {(DW-1){1'b0}}};
            1:       v = {1'b0, {(DW-1){1'b1}}};
            default: v = DW'($urandom);
        endcase
        return v;
    endfunction

    function automatic logic [TW-1:0] rnd_w();
        logic [TW-1:0] v;
        case ($urandom % 5)
            0:       v = {1'b1, {(TW-1){1'b0}}};
            1:       v = {1'b0, {(TW-1){1'b1}}};
            default: v = TW'($urandom);
        endcase
        return v;
    endfunction

    // Drives one sample from posedge+1 and returns just after its transfer edge.
    task automatic send(input logic [DW-1:0] ar, input logic [DW-1:0] ai,
                        input logic [TW-1:0] wr, input logic [TW-1:0] wi,
                        input logic cj, input logic [TAG_W-1:0] tg);
        int n;
        n = 0;
        a_re = ar; a_im = ai; w_re = wr; w_im = wi; in_conj = cj; in_tag = tg;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++; failures++;
            $display("FAIL send_timeout in_ready=%b required=1", in_ready);
        end
        @(posedge clk);
        exp_q.push_back(model(ar, ai, wr, wi, cj, tg));
        #1 in_valid = 1'b0;
    endtask

    task automatic drain(output bit ok);
        int n;
        n = 0;
        out_ready = 1'b1;
        while (obs_q.size() < exp_q.size() && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        ok = (obs_q.size() >= exp_q.size());
        repeat (8) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
        checks++; if (y_re !== '0)       begin failures++; $display("FAIL rst_y_re got=%h want=0", y_re); end
        checks++; if (y_im !== '0)       begin failures++; $display("FAIL rst_y_im got=%h want=0", y_im); end
        checks++; if (out_tag !== '0)    begin failures++; $display("FAIL rst_out_tag got=%h want=0", out_tag); end
        checks++; if (out_sat !== 1'b0)  begin failures++; $display("FAIL rst_out_sat got=%b want=0", out_sat); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_directed;
        int n;
        out_ready = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 7; i++) begin
            a_re = T_AR[i]; a_im = T_AI[i]; w_re = T_WR[i]; w_im = T_WI[i];
            in_conj = T_CJ[i]; in_tag = TAG_W'(i); in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            n = 1;
            while (!out_valid && n < 12) begin @(posedge clk); #1; n++; end
            checks++; if (n != 4) begin failures++; $display("FAIL dir%0d_latency got=%0d want=4", i, n); end
            checks++; if (y_re !== T_YR[i]) begin failures++; $display("FAIL dir%0d_y_re got=%h want=%h", i, y_re, T_YR[i]); end
            checks++; if (y_im !== T_YI[i]) begin failures++; $display("FAIL dir%0d_y_im got=%h want=%h", i, y_im, T_YI[i]); end
            checks++; if (out_sat !== T_S[i]) begin failures++; $display("FAIL dir%0d_sat got=%b want=%b", i, out_sat, T_S[i]); end
            checks++; if (out_tag !== TAG_W'(i)) begin failures++; $display("FAIL dir%0d_tag got=%h want=%h", i, out_tag, TAG_W'(i)); end
            checks++; if (y_re2 !== T_YR2[i] || y_im2 !== T_YI2[i] || out_sat2 !== T_S[i]) begin
                failures++;
                $display("FAIL dir%0d_floorwrap got=%h/%h/%b want=%h/%h/%b", i, y_re2, y_im2, out_sat2, T_YR2[i], T_YI2[i], T_S[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall;
        bit ok;
        int stalls;
        bit pstall;
        logic [DW-1:0] p_re, p_im;
        logic [TAG_W-1:0] p_tag;
        exp_q.delete(); obs_q.delete();
        stalls = 0; pstall = 1'b0; p_re = '0; p_im = '0; p_tag = '0;
        fork
            begin
                for (int t = 0; t < 8; t++)
                    send(rnd_d(), rnd_d(), rnd_w(), rnd_w(), 1'($urandom % 2), TAG_W'(t));
            end
            begin
                for (int c = 0; c < 30; c++) begin
                    @(posedge clk); #1;
                    out_ready = !(c >= 5 && c <= 10);
                    @(negedge clk);
                    checks++;
                    if (in_ready !== (!out_valid || out_ready)) begin
                        failures++;
                        $display("FAIL stall_in_ready c=%0d got=%b want=%b", c, in_ready, !out_valid || out_ready);
                    end
                    if (pstall) begin
                        checks++;
                        if (out_valid !== 1'b1 || y_re !== p_re || y_im !== p_im || out_tag !== p_tag) begin
                            failures++;
                            $display("FAIL stall_hold c=%0d got=%b/%h/%h/%h want=1/%h/%h/%h",
                                     c, out_valid, y_re, y_im, out_tag, p_re, p_im, p_tag);
                        end
                    end
                    pstall = out_valid && !out_ready;
                    if (pstall) stalls++;
                    p_re = y_re; p_im = y_im; p_tag = out_tag;
                end
            end
        join
        drain(ok);
        checks++; if (stalls != 6) begin failures++; $display("FAIL stall_cycles got=%0d want=6", stalls); end
        checks++; if (!ok || obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL stall_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL stall_result%0d got=%h want=%h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random;
        bit ok;
        exp_q.delete(); obs_q.delete();
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    send(rnd_d(), rnd_d(), rnd_w(), rnd_w(), 1'($urandom % 2), TAG_W'(i));
                    if ($urandom % 4 == 0) begin @(posedge clk); #1; end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom % 4) != 0;
                end
                out_ready = 1'b1;
            end
        join
        drain(ok);
        checks++; if (!ok || obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL rand_count got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL rand_result%0d got=%h want=%h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_midflight;
        int n;
        int stale;
        res_t got;
        out_ready = 1'b1;
        exp_q.delete(); obs_q.delete();
        send(16'h1234, 16'h4321, 8'h33, 8'h44, 1'b0, 4'h1);
        send(16'h2345, 16'h5432, 8'h55, 8'h66, 1'b1, 4'h2);
        send(16'h3456, 16'h6543, 8'h77, 8'h11, 1'b0, 4'h3);
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL mid_pre_valid got=%b want=1", out_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_tag !== '0 || y_re !== '0 || out_sat !== 1'b0) begin
            failures++; $display("FAIL mid_async_clear got=%b/%h/%h/%b want=0/0/0/0", out_valid, out_tag, y_re, out_sat);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        exp_q.delete(); obs_q.delete();
        stale = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stale++;
        end
        checks++; if (stale != 0) begin failures++; $display("FAIL mid_stale got=%0d want=0", stale); end
        @(posedge clk); #1;
        send(16'h4000, 16'h4000, 8'h40, 8'h40, 1'b1, 4'h9);
        n = 1;
        while (!out_valid && n < 12) begin @(posedge clk); #1; n++; end
        checks++; if (n != 4) begin failures++; $display("FAIL mid_latency got=%0d want=4", n); end
        got = {out_tag, y_re, y_im, out_sat, y_re2, y_im2, out_sat2};
        checks++; if (exp_q.size() != 1 || got !== exp_q[0]) begin
            failures++; $display("FAIL mid_result got=%h want=%h", got, (exp_q.size() > 0) ? exp_q[0] : res_t'(0));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset;
        test_directed;
        test_stall;
        test_random;
        test_reset_midflight;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
